fifo_sync: RTL
==============

# fifo_sync

Synchronous first-word-fall-through FIFO that buffers 10-bit packets (destination in bits [9:8]) on both sides of the transaction-layer arbiter: four instances feed it as input FIFOs (arbiter reads `empty`, drives `pop`), four consume it as output FIFOs (arbiter reads `almost_full`, drives `push`). It provides single-cycle push/pop, occupancy tracking, programmable almost-full/almost-empty flags and overflow/underflow protection.

## Interface
- `DATA_WIDTH`, 10, packet width in bits.
- `ADDR_WIDTH`, 3, pointer width; depth = 2^ADDR_WIDTH = 8 entries.
- `AF_LEVEL`, 6, `almost_full` asserted when count >= AF_LEVEL.
- `AE_LEVEL`, 1, `almost_empty` asserted when count <= AE_LEVEL.

- `clk`  in  1  single clock, all state updates on the rising edge.
- `reset_L`  in  1  asynchronous, active-low reset.
- `push`  in  1  write enable; writes `data_in` at the next edge if accepted.
- `data_in`  in  DATA_WIDTH  write data.
- `pop`  in  1  read enable; advances the head at the next edge if accepted.
- `data_out`  out  DATA_WIDTH  current head entry (FWFT); 0 when empty.
- `empty`  out  1  count == 0.
- `full`  out  1  count == depth.
- `almost_full`  out  1  count >= AF_LEVEL.
- `almost_empty`  out  1  count <= AE_LEVEL.
- `count`  out  ADDR_WIDTH+1  current occupancy, 0..depth.
- `error`  out  1  sticky overflow/underflow flag (see Configuration).

## Operation
- Storage: depth x DATA_WIDTH register array; write pointer `wr_ptr` and read pointer `rd_ptr`, each ADDR_WIDTH bits, wrap modulo depth (7 -> 0) with no extra logic.
- Occupancy register `count`, ADDR_WIDTH+1 bits; flags decode combinationally from `count` only.
- Accept rules, evaluated on the state before the edge:
  - push accepted iff `!full` or (`full` and `pop`).
  - pop accepted iff `!empty`.
  - push+pop while empty: push accepted, pop rejected (no bypass); count 0 -> 1.
  - push+pop while full: both accepted; count stays at depth, head advances, new entry lands at old `wr_ptr`.
  - push+pop otherwise: both accepted, count unchanged.
- Rejected push: memory and `wr_ptr` unchanged, data discarded. Rejected pop: `rd_ptr` unchanged.
- `data_out` = mem[rd_ptr] when `!empty`, else 0; combinational from registered state, so the arbiter may sample it in the same cycle it asserts `pop`.
- No state machine beyond pointers/count; the block is always ready.

## Timing
- Reset (reset_L low, asynchronous): `wr_ptr`=`rd_ptr`=0, `count`=0, `error`=0, memory cleared to 0. Outputs during/after reset: `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0, `data_out`=0, `count`=0.
- Reset asserted mid-operation discards all contents immediately, without waiting for an edge; deassertion takes effect at the next rising edge.
- Write latency: entry pushed at edge N is visible on `data_out` (if FIFO was empty) and in `count`/flags after edge N, i.e. during cycle N+1.
- Flags change only after clock edges (or reset); never glitch on `push`/`pop` inputs.
- Pop: `data_out` shows next entry during the cycle after the accepted pop edge.

## Configuration
- `FIFO_ERROR_FLAG_EN` defined: `error` sets at the edge where a push is rejected (overflow) or a pop is rejected (underflow), and holds 1 until `reset_L` low.
- Not defined: `error` tied to 0, the sticky register is not built; reject protection of pointers and memory is unchanged.

## Test plan
- Reset then 8 pushes of 0x001..0x008 -> `count`=8, `full`=1, `almost_full`=1 from count 6, `data_out`=0x001 throughout, `empty`=0 after first edge.
- Push 0x3FF with FIFO full, no pop -> contents unchanged, `count`=8, `error`=1 (0 with macro undefined); 8 pops then return 0x001..0x008 in order.
- Pop on empty FIFO -> pointers unchanged, `data_out`=0, `error`=1; push+pop same cycle on empty -> `count`=1, `data_out`=pushed value.
- Full FIFO, push 0x2AA with pop each cycle for 10 cycles -> `count` stays 8, pointers wrap, output order preserved, `error` stays 0.
- Fill to 5 entries, assert `reset_L` low between edges -> `empty`=1, `count`=0, `data_out`=0 immediately; push after release -> normal operation.
- Alternate push-only/pop-only around thresholds -> `almost_empty` high exactly at count 0..1, `almost_full` high exactly at count 6..8.

Source files
------------

// File: rtl/fifo_sync_if.sv
// rtl/fifo_sync_if.sv - handshake and status bundle for fifo_sync
//
// Signals:
//   push, data_in, pop                    driven by the producer/consumer (master)
//   data_out, empty, full, almost_full,
//   almost_empty, count, error            driven by the FIFO (slave)
interface fifo_sync_if #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 3
);
  logic                  push;
  logic [DATA_WIDTH-1:0] data_in;
  logic                  pop;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  empty;
  logic                  full;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   count;
  logic                  error;

  modport master (
    output push, data_in, pop,
    input  data_out, empty, full, almost_full, almost_empty, count, error
  );

  modport slave (
    input  push, data_in, pop,
    output data_out, empty, full, almost_full, almost_empty, count, error
  );
endinterface

// File: rtl/fifo_sync.sv
// rtl/fifo_sync.sv - single-clock first-word-fall-through packet FIFO
//
// Ports:
//   clk      rising-edge clock
//   reset_L  asynchronous active-low reset; clears pointers, count, memory, error
//   bus      fifo_sync_if.slave: push/data_in/pop in; data_out (head, 0 when
//            empty), empty/full/almost_full/almost_empty, count, error out
// Optional feature macro: FIFO_ERROR_FLAG_EN (sticky overflow/underflow flag).
module fifo_sync #(
  parameter int DATA_WIDTH = 10,
  parameter int ADDR_WIDTH = 3,
  parameter int AF_LEVEL   = 6,
  parameter int AE_LEVEL   = 1
) (
  input  logic        clk,
  input  logic        reset_L,
  fifo_sync_if.slave  bus
);

  localparam int                DEPTH   = 1 << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH:0] AF_C    = (ADDR_WIDTH+1)'(AF_LEVEL);
  localparam logic [ADDR_WIDTH:0] AE_C    = (ADDR_WIDTH+1)'(AE_LEVEL);
  localparam logic [ADDR_WIDTH:0] ONE_C   = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,  count_d;

  logic empty_w, full_w;
  logic push_ok, pop_ok;

  // Flags decode from the registered count only, so they never follow push/pop.
  assign empty_w = (count_q == '0);
  assign full_w  = (count_q == DEPTH_C);

  // A push into a full FIFO is only safe when the head leaves in the same edge.
  // A pop on empty is rejected even if a push arrives: there is no bypass path.
  assign push_ok = bus.push && (!full_w || bus.pop);
  assign pop_ok  = bus.pop && !empty_w;

  // Pointers are exactly ADDR_WIDTH bits, so wrap-around is natural overflow.
  assign wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(push_ok);
  assign rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(pop_ok);

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + ONE_C;
      2'b01:   count_d = count_q - ONE_C;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (push_ok) begin
        mem_q[wr_ptr_q] <= bus.data_in;
      end
    end
  end

`ifdef FIFO_ERROR_FLAG_EN
  logic error_q, error_d;

  // Sticky: any rejected request latches until reset.
  assign error_d = error_q | (bus.push && !push_ok) | (bus.pop && !pop_ok);

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      error_q <= 1'b0;
    end else begin
      error_q <= error_d;
    end
  end

  assign bus.error = error_q;
`else
  assign bus.error = 1'b0;
`endif

  assign bus.data_out     = empty_w ? '0 : mem_q[rd_ptr_q];
  assign bus.empty        = empty_w;
  assign bus.full         = full_w;
  assign bus.almost_full  = (count_q >= AF_C);
  assign bus.almost_empty = (count_q <= AE_C);
  assign bus.count        = count_q;

endmodule
